// File: rtl/fetch_queue_pkg.sv
// Shared constants and helpers for the instruction fetch queue.
package fetch_queue_pkg;

    localparam int unsigned DefDepth = 4;
    localparam int unsigned DefAw    = 16;
    localparam int unsigned DefDw    = 16;

    localparam logic [15:0] NOP_INSTR = 16'h0000;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int unsigned occ_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// ROM and core-side signals of the fetch queue. Optional bubble_cnt exists only when
// FETCH_PERF_CNT_EN is defined.
interface fetch_queue_if #(
    parameter int unsigned DEPTH = fetch_queue_pkg::DefDepth,
    parameter int unsigned AW    = fetch_queue_pkg::DefAw,
    parameter int unsigned DW    = fetch_queue_pkg::DefDw
);
    import fetch_queue_pkg::*;

    localparam int unsigned OW = occ_width(DEPTH);

    logic          rom_req;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic          stall;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic [DW-1:0] instruction;
    logic [AW-1:0] instr_pc;
    logic          instr_valid;
    logic [OW-1:0] occupancy;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0]   bubble_cnt;
`endif

    modport master (
        output rom_req, rom_addr, instruction, instr_pc, instr_valid, occupancy,
        input  rom_data, stall, redirect, redirect_pc
`ifdef FETCH_PERF_CNT_EN
        , output bubble_cnt
`endif
    );

    modport slave (
        input  rom_req, rom_addr, instruction, instr_pc, instr_valid, occupancy,
        output rom_data, stall, redirect, redirect_pc
`ifdef FETCH_PERF_CNT_EN
        , input bubble_cnt
`endif
    );

endinterface

// File: rtl/fetch_queue_fifo.sv
// Prefetch FIFO holding instruction word plus fetch pc per entry, with synchronous flush.
module fetch_queue_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 16,
    parameter int unsigned DW    = 16,
    parameter int unsigned OW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic [AW-1:0] push_pc,
    input  logic          pop,
    input  logic          flush,
    output logic [DW-1:0] head_data,
    output logic [AW-1:0] head_pc,
    output logic          head_valid,
    output logic [OW-1:0] count
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [DW-1:0] data_q [DEPTH];
    logic [AW-1:0] pc_q   [DEPTH];
    logic [PW-1:0] head_q, tail_q;
    logic [OW-1:0] count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) tail_q <= tail_q + PW'(1);
            if (pop)  head_q <= head_q + PW'(1);
            count_q <= count_q + OW'(push) - OW'(pop);
        end
    end

    // Storage needs no reset; reads are qualified by head_valid.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            data_q[tail_q] <= push_data;
            pc_q[tail_q]   <= push_pc;
        end
    end

    assign head_valid = (count_q != '0);
    assign head_data  = data_q[head_q];
    assign head_pc    = pc_q[head_q];
    assign count      = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch stage: sequential ROM reads into a prefetch FIFO, stall hold and redirect
// flush. Defining FETCH_PERF_CNT_EN adds the saturating bubble_cnt counter.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = DefDepth,
    parameter int unsigned AW    = DefAw,
    parameter int unsigned DW    = DefDw
) (
    input logic          clk,
    input logic          rst,
    fetch_queue_if.master bus
);
    localparam int unsigned OW = occ_width(DEPTH);

    logic [AW-1:0] fetch_pc_q, req_pc_q;
    logic          inflight_q;
    logic          push, pop;
    logic [DW-1:0] head_data;
    logic [AW-1:0] head_pc;
    logic          head_valid;
    logic [OW:0]   pending;

    // Every in-flight word already owns a FIFO slot, so a push can never overflow.
    assign pending     = {1'b0, bus.occupancy} + (OW+1)'(inflight_q);
    assign bus.rom_req = !bus.redirect && (pending < (OW+1)'(DEPTH));
    assign bus.rom_addr = fetch_pc_q;

    assign push = inflight_q && !bus.redirect;
    assign pop  = head_valid && !bus.stall && !bus.redirect;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= '0;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            // rom_req is low during redirect, which also kills the outstanding read.
            inflight_q <= bus.rom_req;
            if (bus.redirect) begin
                fetch_pc_q <= bus.redirect_pc;
            end else if (bus.rom_req) begin
                fetch_pc_q <= fetch_pc_q + AW'(1);
                req_pc_q   <= fetch_pc_q;
            end
        end
    end

    fetch_queue_fifo #(
        .DEPTH(DEPTH),
        .AW   (AW),
        .DW   (DW),
        .OW   (OW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (bus.rom_data),
        .push_pc   (req_pc_q),
        .pop       (pop),
        .flush     (bus.redirect),
        .head_data (head_data),
        .head_pc   (head_pc),
        .head_valid(head_valid),
        .count     (bus.occupancy)
    );

    assign bus.instr_valid = head_valid;
    assign bus.instruction = head_valid ? head_data : DW'(NOP_INSTR);
    assign bus.instr_pc    = head_valid ? head_pc : '0;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] bubble_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bubble_q <= '0;
        end else if (!head_valid && !bus.stall && (bubble_q != 16'hFFFF)) begin
            bubble_q <= bubble_q + 16'd1;
        end
    end

    assign bus.bubble_cnt = bubble_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: cycle table plus scoreboard over ROM requests.
module tb_fetch_queue;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 16;
    localparam int unsigned DW    = 16;
    localparam int NV = 37;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fetch_queue_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

    fetch_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic logic [15:0] rom_word(input logic [15:0] a);
        return 16'hA000 + a;
    endfunction

    // ROM answers one cycle after a request; otherwise drives a poison value.
    always @(posedge clk) begin
        if (bus.rom_req) bus.rom_data <= rom_word(bus.rom_addr);
        else             bus.rom_data <= 16'hDEAD;
    end

    typedef struct {
        logic        stall;
        logic        redirect;
        logic [15:0] rpc;
        logic        req;
        logic [15:0] addr;
        logic        valid;
        logic [15:0] pc;
        logic [2:0]  occ;
    } vec_t;

    vec_t vecs [NV];

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] exp_q [$];
    logic [15:0] m_pc = '0;
    int          m_inf = 0;
    int          m_bub = 0;
    logic        prev_hold = 1'b0;
    logic [15:0] prev_pc, prev_instr;

    function automatic vec_t v(input int s, input int r, input int rp, input int q,
                               input int a, input int vl, input int p, input int o);
        vec_t x;
        x.stall = s[0]; x.redirect = r[0]; x.rpc = rp[15:0]; x.req = q[0];
        x.addr = a[15:0]; x.valid = vl[0]; x.pc = p[15:0]; x.occ = o[2:0];
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Model-based checks on the pre-edge sample, then advance one clock.
    task automatic cyc();
        int          m_occ;
        logic        m_req;
        logic [15:0] pc;
        #1;
        m_occ = exp_q.size() - m_inf;
        m_req = !bus.redirect && (exp_q.size() < DEPTH);
        check("occupancy", 32'(bus.occupancy), m_occ);
        check("instr_valid", 32'(bus.instr_valid), 32'(m_occ != 0));
        check("rom_req", 32'(bus.rom_req), 32'(m_req));
        if (m_req) check("rom_addr", 32'(bus.rom_addr), 32'(m_pc));
        if (m_occ == 0) check("empty_instr", 32'(bus.instruction), 0);
        if (prev_hold) begin
            check("stall_hold_pc", 32'(bus.instr_pc), 32'(prev_pc));
            check("stall_hold_instr", 32'(bus.instruction), 32'(prev_instr));
        end
        prev_hold  = (m_occ != 0) && bus.stall && !bus.redirect;
        prev_pc    = bus.instr_pc;
        prev_instr = bus.instruction;
`ifdef FETCH_PERF_CNT_EN
        check("bubble_cnt", 32'(bus.bubble_cnt), m_bub);
        if (m_occ == 0 && !bus.stall && m_bub < 65535) m_bub++;
`endif
        if (bus.redirect) begin
            exp_q.delete();
            m_inf = 0;
            m_pc  = bus.redirect_pc;
        end else begin
            if (m_occ != 0 && !bus.stall) begin
                pc = exp_q.pop_front();
                check("sb_pc", 32'(bus.instr_pc), 32'(pc));
                check("sb_instr", 32'(bus.instruction), 32'(rom_word(pc)));
            end
            if (m_req) begin
                exp_q.push_back(m_pc);
                m_pc  = m_pc + 16'd1;
                m_inf = 1;
            end else begin
                m_inf = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        //             stall red rpc     req addr    vld pc      occ
        vecs[0]  = v(0, 0, 0,       1, 0,       0, 0,       0);
        vecs[1]  = v(0, 0, 0,       1, 1,       0, 0,       0);
        vecs[2]  = v(0, 0, 0,       1, 2,       1, 0,       1);
        vecs[3]  = v(0, 0, 0,       1, 3,       1, 1,       1);
        vecs[4]  = v(1, 0, 0,       1, 4,       1, 2,       1);
        vecs[5]  = v(1, 0, 0,       1, 5,       1, 2,       2);
        vecs[6]  = v(1, 0, 0,       0, 6,       1, 2,       3);
        for (int i = 7; i <= 13; i++) vecs[i] = v(1, 0, 0, 0, 6, 1, 2, 4);
        vecs[14] = v(0, 0, 0,       0, 6,       1, 2,       4);
        vecs[15] = v(0, 0, 0,       1, 6,       1, 3,       3);
        vecs[16] = v(0, 0, 0,       1, 7,       1, 4,       2);
        vecs[17] = v(0, 0, 0,       1, 8,       1, 5,       2);
        vecs[18] = v(0, 0, 0,       1, 9,       1, 6,       2);
        vecs[19] = v(1, 0, 0,       1, 'hA,     1, 7,       2);
        vecs[20] = v(0, 1, 'h100,   0, 'hB,     1, 7,       3);
        vecs[21] = v(0, 0, 0,       1, 'h100,   0, 0,       0);
        vecs[22] = v(0, 0, 0,       1, 'h101,   0, 0,       0);
        vecs[23] = v(0, 0, 0,       1, 'h102,   1, 'h100,   1);
        vecs[24] = v(1, 1, 'h200,   0, 'h103,   1, 'h101,   1);
        vecs[25] = v(0, 0, 0,       1, 'h200,   0, 0,       0);
        vecs[26] = v(0, 1, 'h300,   0, 'h201,   0, 0,       0);
        vecs[27] = v(0, 1, 'h400,   0, 'h300,   0, 0,       0);
        vecs[28] = v(0, 0, 0,       1, 'h400,   0, 0,       0);
        vecs[29] = v(0, 0, 0,       1, 'h401,   0, 0,       0);
        vecs[30] = v(0, 0, 0,       1, 'h402,   1, 'h400,   1);
        vecs[31] = v(0, 1, 'hFFFE,  0, 'h403,   1, 'h401,   1);
        vecs[32] = v(0, 0, 0,       1, 'hFFFE,  0, 0,       0);
        vecs[33] = v(0, 0, 0,       1, 'hFFFF,  0, 0,       0);
        vecs[34] = v(0, 0, 0,       1, 0,       1, 'hFFFE,  1);
        vecs[35] = v(0, 0, 0,       1, 1,       1, 'hFFFF,  1);
        vecs[36] = v(0, 0, 0,       1, 2,       1, 0,       1);

        bus.stall       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            bus.stall       = vecs[i].stall;
            bus.redirect    = vecs[i].redirect;
            bus.redirect_pc = vecs[i].rpc;
            #1;
            check($sformatf("v%0d_req", i), 32'(bus.rom_req), 32'(vecs[i].req));
            check($sformatf("v%0d_addr", i), 32'(bus.rom_addr), 32'(vecs[i].addr));
            check($sformatf("v%0d_valid", i), 32'(bus.instr_valid), 32'(vecs[i].valid));
            check($sformatf("v%0d_pc", i), 32'(bus.instr_pc), 32'(vecs[i].pc));
            check($sformatf("v%0d_occ", i), 32'(bus.occupancy), 32'(vecs[i].occ));
            check($sformatf("v%0d_instr", i), 32'(bus.instruction),
                  vecs[i].valid ? 32'(rom_word(vecs[i].pc)) : 32'h0);
            cyc();
        end

        // Random stall/redirect traffic against the scoreboard.
        for (int i = 0; i < 300; i++) begin
            bus.stall       = ($urandom_range(0, 3) == 0);
            bus.redirect    = ($urandom_range(0, 15) == 0);
            bus.redirect_pc = 16'($urandom);
            cyc();
        end

        // Asynchronous reset in mid-stream.
        bus.stall    = 1'b0;
        bus.redirect = 1'b0;
        repeat (4) cyc();
        #2;
        rst = 1'b0;
        #1;
        check("rst_valid", 32'(bus.instr_valid), 0);
        check("rst_occ", 32'(bus.occupancy), 0);
        check("rst_instr", 32'(bus.instruction), 0);
        check("rst_pc", 32'(bus.instr_pc), 0);
        check("rst_addr", 32'(bus.rom_addr), 0);
        check("rst_req", 32'(bus.rom_req), 1);
`ifdef FETCH_PERF_CNT_EN
        check("rst_bubble", 32'(bus.bubble_cnt), 0);
`endif
        exp_q.delete();
        m_inf     = 0;
        m_pc      = '0;
        m_bub     = 0;
        prev_hold = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (12) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
